dual_issue_sched: RTL

//  Issue scheduler between ID and the dual-issue EX stage. Per cycle decides whether slot0, slot1, both or neither of
//  the decoded pair issue. Splits pairs the EX forwarding network cannot cover (same-pair load-use, two memory ops on one

---
 rtl/dual_issue_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/dual_issue_sched.sv
// Dual-issue scheduler between ID and EX: splits uncoverable pairs and stalls on in-flight loads.
// Optional build macro SCHED_PERF_CNT_EN adds split/stall performance counters.
module dual_issue_sched #(
  parameter int RF_ADDR_WIDTH = 5,
  parameter int LD_LAT        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     mem_stall,
  input  logic                     id0_valid,
  input  logic [RF_ADDR_WIDTH-1:0] id0_rs1addr,
  input  logic [RF_ADDR_WIDTH-1:0] id0_rs2addr,
  input  logic [RF_ADDR_WIDTH-1:0] id0_rdaddr,
  input  logic                     id0_RdWrtEn,
  input  logic                     id0_LdEn,
  input  logic                     id0_MemEn,
  input  logic                     id1_valid,
  input  logic [RF_ADDR_WIDTH-1:0] id1_rs1addr,
  input  logic [RF_ADDR_WIDTH-1:0] id1_rs2addr,
  input  logic [RF_ADDR_WIDTH-1:0] id1_rdaddr,
  input  logic                     id1_RdWrtEn,
  input  logic                     id1_LdEn,
  input  logic                     id1_MemEn,
  output logic                     issue0_en,
  output logic                     issue1_en,
  output logic                     id_stall,
  output logic                     sched_split,
  output logic [31:0]              perf_split_cnt,
  output logic [31:0]              perf_stall_cnt
);

  localparam int NREG = 1 << RF_ADDR_WIDTH;
  localparam logic [0:0] ST_PAIR  = 1'b0;
  localparam logic [0:0] ST_SLOT1 = 1'b1;
  localparam logic [2:0] LD_LAT_C = 3'(LD_LAT);
  localparam logic [RF_ADDR_WIDTH-1:0] REG_X0 = {RF_ADDR_WIDTH{1'b0}};

  logic [0:0]      state_q, state_d;
  logic [2:0]      cnt_q [NREG];
  logic [NREG-1:0] busy_s;
  logic            haz0_s, haz1_s, split_s;
  logic            ld0_set_s, ld1_set_s;

  // Register 0 is hardwired, so it is never reported busy.
  always_comb begin
    busy_s = {NREG{1'b0}};
    for (int r = 1; r < NREG; r++) begin
      busy_s[r] = (cnt_q[r] != 3'd0);
    end
  end

  assign haz0_s = id0_valid && (busy_s[id0_rs1addr] || busy_s[id0_rs2addr]);
  assign haz1_s = id1_valid && (busy_s[id1_rs1addr] || busy_s[id1_rs2addr]);

  // Pairs the forwarding network cannot cover: in-pair load-use, dual memory op, in-pair WAW.
  assign split_s =
      (id0_LdEn && id0_RdWrtEn && (id0_rdaddr != REG_X0) &&
       ((id1_rs1addr == id0_rdaddr) || (id1_rs2addr == id0_rdaddr))) ||
      (id0_MemEn && id1_MemEn) ||
      (id0_RdWrtEn && id1_RdWrtEn && (id0_rdaddr == id1_rdaddr) && (id0_rdaddr != REG_X0));

  // Issue decision and next state.
  always_comb begin
    issue0_en   = 1'b0;
    issue1_en   = 1'b0;
    id_stall    = 1'b0;
    state_d     = state_q;
    sched_split = !rst && !mem_stall && (state_q == ST_SLOT1);
    if (rst || flush) begin
      state_d = ST_PAIR;
    end else if (mem_stall) begin
      id_stall = id0_valid || id1_valid;
    end else begin
      case (state_q)
        ST_PAIR: begin
          if (id0_valid) begin
            issue0_en = !haz0_s;
            issue1_en = !haz0_s && id1_valid && !haz1_s && !split_s;
            id_stall  = !(issue0_en && (!id1_valid || issue1_en));
            state_d   = (issue0_en && id1_valid && !issue1_en) ? ST_SLOT1 : ST_PAIR;
          end else begin
            state_d = ST_PAIR;
          end
        end
        ST_SLOT1: begin
          issue1_en = id1_valid && !haz1_s;
          id_stall  = !issue1_en;
          state_d   = issue1_en ? ST_PAIR : ST_SLOT1;
        end
        default: begin
          state_d = ST_PAIR;
        end
      endcase
    end
  end

  // Scheduler state register; mem_stall holds via state_d.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PAIR;
    end else begin
      state_q <= state_d;
    end
  end

  assign ld0_set_s = issue0_en && id0_LdEn && id0_RdWrtEn && (id0_rdaddr != REG_X0);
  assign ld1_set_s = issue1_en && id1_LdEn && id1_RdWrtEn && (id1_rdaddr != REG_X0);

  // Load scoreboard: a fresh load reloads the count, otherwise busy entries count down.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= 3'd0;
      end
    end else if (!mem_stall) begin
      for (int r = 0; r < NREG; r++) begin
        if ((ld0_set_s && (id0_rdaddr == RF_ADDR_WIDTH'(r))) ||
            (ld1_set_s && (id1_rdaddr == RF_ADDR_WIDTH'(r)))) begin
          cnt_q[r] <= LD_LAT_C;
        end else if (cnt_q[r] != 3'd0) begin
          cnt_q[r] <= cnt_q[r] - 3'd1;
        end else begin
          cnt_q[r] <= 3'd0;
        end
      end
    end
  end

`ifdef SCHED_PERF_CNT_EN
  logic [31:0] split_cnt_q, stall_cnt_q;

  // Performance counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      split_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      if ((state_q == ST_PAIR) && (state_d == ST_SLOT1)) begin
        split_cnt_q <= split_cnt_q + 32'd1;
      end
      if (id_stall && !issue0_en && !issue1_en && !mem_stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_split_cnt = split_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_split_cnt = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule
